// File: rtl/prog_seq_pkg.sv
// Shared op codes and sizing helper for the programmable sequencer.
package prog_seq_pkg;

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_INC   = 3'b001;
   localparam logic [2:0] OP_LOAD  = 3'b010;
   localparam logic [2:0] OP_BRREL = 3'b011;
   localparam logic [2:0] OP_CALL  = 3'b100;
   localparam logic [2:0] OP_RET   = 3'b101;

   // Width needed to count 0..depth occupied stack entries.
   function automatic int sp_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/prog_seq_ret_stack.sv
// DEPTH x AW return-address LIFO with occupancy count; storage itself is not reset.
module ret_stack
   import prog_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [AW-1:0]                push_data,
   output logic [AW-1:0]                top,
   output logic [sp_width(DEPTH)-1:0]   count
);

   localparam int SPW = sp_width(DEPTH);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]  mem_q [0:(2**IW)-1];
   logic [SPW-1:0] count_q;
   logic [SPW-1:0] count_d;
   logic           full_s;
   logic           empty_s;
   logic           wr_s;
   logic [IW-1:0]  wr_idx_s;
   logic [IW-1:0]  top_idx_s;

   assign full_s    = (count_q == SPW'(DEPTH));
   assign empty_s   = (count_q == {SPW{1'b0}});
   assign wr_idx_s  = count_q[IW-1:0];
   // A full power-of-two stack wraps wr_idx to 0, so top still lands on DEPTH-1.
   assign top_idx_s = wr_idx_s - IW'(1'b1);
   assign top       = empty_s ? {AW{1'b0}} : mem_q[top_idx_s];
   assign count     = count_q;

   // Occupancy update; overflow and underflow requests are ignored here.
   always_comb begin
      count_d = count_q;
      wr_s    = 1'b0;
      if (push && !full_s) begin
         wr_s    = 1'b1;
         count_d = count_q + SPW'(1'b1);
      end else if (pop && !empty_s) begin
         count_d = count_q - SPW'(1'b1);
      end else begin
         count_d = count_q;
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {SPW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_q[wr_idx_s] <= push_data;
      end
   end

endmodule

// File: rtl/prog_seq.sv
// Program-counter sequencer: step, load, relative branch, call/return with sticky error.
module prog_seq
   import prog_seq_pkg::*;
#(
   parameter int AW    = 4,
   parameter int TW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [2:0]                   op,
   input  logic [TW-1:0]                target,
   input  logic                         err_clr,
   output logic [AW-1:0]                pc,
   output logic [sp_width(DEPTH)-1:0]   sp,
   output logic                         stk_full,
   output logic                         stk_empty,
   output logic                         err
);

   localparam int SPW = sp_width(DEPTH);

   logic [AW-1:0]  pc_q;
   logic [AW-1:0]  pc_d;
   logic           err_q;
   logic           err_d;
   logic           push_s;
   logic           pop_s;
   logic [AW-1:0]  ret_addr_s;
   logic [AW-1:0]  top_s;
   logic [SPW-1:0] sp_s;

   ret_stack #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (ret_addr_s),
      .top       (top_s),
      .count     (sp_s)
   );

   if (TW > AW) begin : g_upper
      // Bits above AW cannot affect an AW-bit result, even for sign-extended offsets.
      logic unused_target_s;
      assign unused_target_s = ^target[TW-1:AW];
   end

   assign ret_addr_s = pc_q + AW'(1'b1);
   assign sp         = sp_s;
   assign stk_full   = (sp_s == SPW'(DEPTH));
   assign stk_empty  = (sp_s == {SPW{1'b0}});
   assign pc         = pc_q;
   assign err        = err_q;

   // Op decode; error set is evaluated after clear so a same-cycle error wins.
   always_comb begin
      pc_d   = pc_q;
      err_d  = err_q;
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      if (en) begin
         case (op)
            OP_HOLD:  pc_d = pc_q;
            OP_INC:   pc_d = pc_q + AW'(1'b1);
            OP_LOAD:  pc_d = target[AW-1:0];
            OP_BRREL: pc_d = pc_q + target[AW-1:0];
            OP_CALL: begin
               if (stk_full) begin
                  err_d = 1'b1;
               end else begin
                  push_s = 1'b1;
                  pc_d   = target[AW-1:0];
               end
            end
            OP_RET: begin
               if (stk_empty) begin
                  err_d = 1'b1;
               end else begin
                  pop_s = 1'b1;
                  pc_d  = top_s;
               end
            end
            default: err_d = 1'b1;
         endcase
      end else begin
         pc_d = pc_q;
      end
   end

   // Architectural state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= {AW{1'b0}};
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_seq.sv
// Scoreboard bench for prog_seq (AW=4, TW=8, DEPTH=4) driven by directed vectors.
module tb_prog_seq;
   import prog_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] op;
   logic [7:0] target;
   logic       err_clr;
   logic [3:0] pc;
   logic [2:0] sp;
   logic       stk_full;
   logic       stk_empty;
   logic       err;

   typedef struct {
      int         due;
      logic [3:0] pc;
      logic [2:0] sp;
      logic       err;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   prog_seq #(.AW(4), .TW(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .op        (op),
      .target    (target),
      .err_clr   (err_clr),
      .pc        (pc),
      .sp        (sp),
      .stk_full  (stk_full),
      .stk_empty (stk_empty),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [3:0] ep,
                                 input logic [2:0] es, input logic ee);
      logic ef;
      logic em;
      ef = (es == 3'd4);
      em = (es == 3'd0);
      n_chk++;
      if (pc !== ep || sp !== es || err !== ee || stk_full !== ef || stk_empty !== em) begin
         n_fail++;
         $display("FAIL %s: got pc=%0d sp=%0d err=%0d full=%0d empty=%0d, expected pc=%0d sp=%0d err=%0d full=%0d empty=%0d",
                  nm, pc, sp, err, stk_full, stk_empty, ep, es, ee, ef, em);
      end
   endfunction

   // Monitor: compare every expectation that has come due.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.due < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: expectation stale, due cycle %0d checked at %0d", e.nm, e.due, cyc);
         end else begin
            check(e.nm, e.pc, e.sp, e.err);
         end
      end
   end

   task automatic step(input logic [2:0] o, input logic [7:0] t, input logic e,
                       input logic c, input logic [3:0] ep, input logic [2:0] es,
                       input logic ee, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      op      = o;
      target  = t;
      en      = e;
      err_clr = c;
      x.due = cyc + 1;
      x.pc  = ep;
      x.sp  = es;
      x.err = ee;
      x.nm  = nm;
      sb.push_back(x);
   endtask

   task automatic async_reset(input string nm);
      exp_t x;
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check({nm, "_immediate"}, 4'd0, 3'd0, 1'b0);
      x.due = cyc + 1;
      x.pc  = 4'd0;
      x.sp  = 3'd0;
      x.err = 1'b0;
      x.nm  = {nm, "_held"};
      sb.push_back(x);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      en      = 1'b0;
      op      = OP_HOLD;
      target  = 8'h00;
      err_clr = 1'b0;
      #12;
      check("reset_state", 4'd0, 3'd0, 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 1; i <= 17; i++) begin
         step(OP_INC, 8'h00, 1'b1, 1'b0, 4'(i % 16), 3'd0, 1'b0, $sformatf("inc%0d", i));
      end
      step(OP_HOLD,  8'h77, 1'b1, 1'b0, 4'd1,  3'd0, 1'b0, "hold");
      step(OP_LOAD,  8'hF3, 1'b1, 1'b0, 4'd3,  3'd0, 1'b0, "load_upper_ignored");
      step(OP_BRREL, 8'hFE, 1'b1, 1'b0, 4'd1,  3'd0, 1'b0, "brrel_m2");
      step(OP_BRREL, 8'hFD, 1'b1, 1'b0, 4'd14, 3'd0, 1'b0, "brrel_m3_wrap");
      step(OP_BRREL, 8'h05, 1'b1, 1'b0, 4'd3,  3'd0, 1'b0, "brrel_p5_wrap");
      step(OP_LOAD,  8'h02, 1'b1, 1'b0, 4'd2,  3'd0, 1'b0, "load2");

      step(OP_CALL, 8'h09, 1'b1, 1'b0, 4'd9,  3'd1, 1'b0, "call9");
      step(OP_CALL, 8'h0C, 1'b1, 1'b0, 4'd12, 3'd2, 1'b0, "call12");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd10, 3'd1, 1'b0, "ret_to10");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd3,  3'd0, 1'b0, "ret_to3");

      step(OP_CALL, 8'h01, 1'b1, 1'b0, 4'd1, 3'd1, 1'b0, "fill1");
      step(OP_CALL, 8'h02, 1'b1, 1'b0, 4'd2, 3'd2, 1'b0, "fill2");
      step(OP_CALL, 8'h03, 1'b1, 1'b0, 4'd3, 3'd3, 1'b0, "fill3");
      step(OP_CALL, 8'h04, 1'b1, 1'b0, 4'd4, 3'd4, 1'b0, "fill4_full");
      step(OP_CALL, 8'h05, 1'b1, 1'b0, 4'd4, 3'd4, 1'b1, "call_overflow");
      step(OP_HOLD, 8'h00, 1'b0, 1'b1, 4'd4, 3'd4, 1'b0, "clr_while_stalled");
      step(OP_CALL, 8'h06, 1'b1, 1'b1, 4'd4, 3'd4, 1'b1, "set_beats_clr");
      step(OP_HOLD, 8'h00, 1'b1, 1'b1, 4'd4, 3'd4, 1'b0, "clr_again");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd4, 3'd3, 1'b0, "pop4");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd3, 3'd2, 1'b0, "pop3");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd2, 3'd1, 1'b0, "pop2");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd4, 3'd0, 1'b0, "pop1");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd4, 3'd0, 1'b1, "ret_underflow");
      step(OP_HOLD, 8'h00, 1'b0, 1'b1, 4'd4, 3'd0, 1'b0, "clr_underflow");

      step(OP_CALL, 8'h07, 1'b1, 1'b0, 4'd7, 3'd1, 1'b0, "call7");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd5, 3'd0, 1'b0, "ret_back_to_back");

      for (int i = 0; i < 3; i++) begin
         step(OP_CALL, 8'h09, 1'b0, 1'b0, 4'd5, 3'd0, 1'b0, $sformatf("stall%0d", i));
      end
      step(3'b111,   8'h0A, 1'b1, 1'b0, 4'd5, 3'd0, 1'b1, "reserved111");
      step(OP_HOLD,  8'h00, 1'b0, 1'b1, 4'd5, 3'd0, 1'b0, "clr_reserved");
      step(3'b110,   8'h0A, 1'b1, 1'b0, 4'd5, 3'd0, 1'b1, "reserved110");
      step(OP_HOLD,  8'h00, 1'b0, 1'b1, 4'd5, 3'd0, 1'b0, "clr_reserved2");

      step(OP_CALL, 8'h09, 1'b1, 1'b0, 4'd9,  3'd1, 1'b0, "pre_rst_call9");
      step(OP_CALL, 8'h0C, 1'b1, 1'b0, 4'd12, 3'd2, 1'b0, "pre_rst_call12");
      step(OP_HOLD, 8'h00, 1'b0, 1'b0, 4'd12, 3'd2, 1'b0, "pre_rst_idle");
      async_reset("midseq_reset");
      step(OP_RET,  8'h00, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1, "ret_after_reset");
      step(OP_INC,  8'h00, 1'b1, 1'b0, 4'd1, 3'd0, 1'b1, "inc_after_reset");

      @(posedge clk);
      #1;
      en = 1'b0;
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin
         @(posedge clk);
      end
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
